// File: rtl/regbank_pkg.sv
// Shared register-bank definitions.
// Holds the architectural register geometry and the debug dump FSM state
// encoding. The register bank and the trace unit also import this package.
package regbank_pkg;

  localparam int REG_AW    = 5;
  localparam int REG_DW    = 32;
  localparam int REG_COUNT = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND0,
    SEND1,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regbank_dump.sv
// regbank_dump: sequential debug reader for the register bank read ports.
// On a start pulse it walks the registers two at a time (one READ cycle per
// pair on A1/A2), captures RD1/RD2, and streams (address, data) words over a
// valid/ready handshake. Each pair is sampled in its own READ cycle, so the
// dump is not a global snapshot.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start                begin a dump; ignored unless idle
//   busy, done           busy from READ through DONE; done is a 1-cycle pulse
//   rb_a1/rb_a2          read addresses to the bank (2k, 2k+1)
//   rb_rd1/rb_rd2        combinational read data from the bank
//   out_valid/out_ready  stream handshake
//   out_addr/out_data    register index and contents
//   out_last             marks the word for register NREGS-1
module regbank_dump
  import regbank_pkg::*;
#(
  parameter int NREGS = REG_COUNT,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rb_a1,
  output logic [AW-1:0] rb_a2,
  input  logic [DW-1:0] rb_rd1,
  input  logic [DW-1:0] rb_rd2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam logic [AW-1:0] K_LAST = AW'(NREGS / 2 - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic [DW-1:0] buf2_q, buf2_d;

  logic [AW-1:0] addr_even, addr_odd;
  logic          last_pair;

  // Addresses stay at AW width; 2k+1 <= NREGS-1 <= 2**AW-1 so nothing wraps.
  assign addr_even = k_q << 1;
  assign addr_odd  = addr_even | AW'(1);
  assign last_pair = (k_q == K_LAST);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    busy      = 1'b0;
    done      = 1'b0;
    rb_a1     = '0;
    rb_a2     = '0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = '0;
        end
      end
      READ: begin
        busy    = 1'b1;
        rb_a1   = addr_even;
        rb_a2   = addr_odd;
        buf1_d  = rb_rd1;
        buf2_d  = rb_rd2;
        state_d = SEND0;
      end
      SEND0: begin
        busy      = 1'b1;
        rb_a1     = addr_even;
        rb_a2     = addr_odd;
        out_valid = 1'b1;
        out_addr  = addr_even;
        out_data  = buf1_q;
        if (out_ready) state_d = SEND1;
      end
      SEND1: begin
        busy      = 1'b1;
        rb_a1     = addr_even;
        rb_a2     = addr_odd;
        out_valid = 1'b1;
        out_addr  = addr_odd;
        out_data  = buf2_q;
        out_last  = last_pair;
        if (out_ready) begin
          if (last_pair) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            k_d     = k_q + AW'(1);
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here: a new dump needs IDLE.
        busy    = 1'b1;
        done    = 1'b1;
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      buf1_q  <= '0;
      buf2_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf1_q  <= buf1_d;
      buf2_q  <= buf2_d;
    end
  end

endmodule

// File: doc/regbank_dump.md
Name: regbank_dump

Overview:
- Sequential debug reader for the `register_bank` read ports (`A1`/`RD1`, `A2`/`RD2`); it sits on the other side of that interface from the core's operand fetch.
- On a `start` pulse it walks every architectural register two at a time, captures both read values, and streams them out as (address, data) words over a valid/ready handshake.
- The stream feeds the debug/trace path used to check uniciclo program results, so benches no longer probe registers one by one.

Parameters:
- NREGS, 32, number of registers walked; must be even and at least 2.
- AW, 5, register address width; NREGS must not exceed 2**AW.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- busy  output  1  high from the cycle after accepted start until the done cycle, inclusive.
- done  output  1  one-cycle pulse after the last word is accepted.
- rb_a1  output  AW  address to register_bank A1.
- rb_a2  output  AW  address to register_bank A2.
- rb_rd1  input  DW  register_bank RD1; combinational read of rb_a1.
- rb_rd2  input  DW  register_bank RD2; combinational read of rb_a2.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts the word this cycle.
- out_addr  output  AW  register index of out_data.
- out_data  output  DW  register contents.
- out_last  output  1  marks the word for register NREGS-1.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - state=IDLE, pair counter k=0, capture buffers cleared.
  - busy, done, out_valid, out_last = 0; rb_a1, rb_a2, out_addr, out_data = 0.
  - Reset mid-dump aborts immediately; no done pulse; the dump does not resume.
- States:
  - IDLE -> READ on start.
  - READ -> SEND0 unconditionally (1 cycle).
  - SEND0 -> SEND1 on out_ready.
  - SEND1 -> READ on out_ready if k<NREGS/2-1, with k incremented.
  - SEND1 -> DONE on out_ready if k=NREGS/2-1.
  - DONE -> IDLE (1 cycle).
- READ:
  - rb_a1=2k, rb_a2=2k+1.
  - At the clock edge, buf1<=rb_rd1 and buf2<=rb_rd2.
- rb_a1/rb_a2 hold their READ values in SEND0/SEND1 and are 0 in IDLE and DONE.
- SEND0: out_valid=1, out_addr=2k, out_data=buf1, out_last=0.
- SEND1: out_valid=1, out_addr=2k+1, out_data=buf2, out_last=(k=NREGS/2-1).
- Handshake:
  - A word transfers on a clock edge with out_valid&out_ready.
  - While out_valid=1 and out_ready=0, out_addr/out_data/out_last stay stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- Throughput: 3 cycles per pair with out_ready tied high, so a full dump takes 3*NREGS/2 cycles from start to the last transfer, then 1 DONE cycle.
  - NREGS=32 gives 48+1 cycles.
- done: high only in the DONE state. busy: high in READ, SEND0, SEND1 and DONE.
- start while busy is ignored; no queuing. start asserted in the DONE cycle is also ignored.
- Register 0 is dumped like any other and carries whatever the bank returns (0 for RISC-V x0).
- Coherency: each pair is sampled in its own READ cycle. Writes to the bank during a dump are reflected only for pairs not yet read; there is no global snapshot.
- Addresses are computed at AW width; 2k+1 never exceeds NREGS-1.

Decomposition:
- Shared package `regbank_pkg`:
  - localparams REG_AW=5, REG_DW=32, REG_COUNT=32.
  - enum `dump_state_t` {IDLE, READ, SEND0, SEND1, DONE}.
  - Reused later by `register_bank` and the trace unit.
- Single module. The FSM, the counter and the two capture buffers are too small to justify a sub-module.

Test Plan:
- Preload bank reg5=0xA5A5A5A5, reg10=0x5A5A5A5A, others 0; pulse start with out_ready=1 -> 32 words, addr 0..31 in order; addr5 data 0xA5A5A5A5, addr10 data 0x5A5A5A5A, rest 0; out_last only on addr31; done pulses 49 cycles after start; busy then drops.
- Same preload, out_ready toggling 1-0-0-1 repeatedly -> identical word sequence; out_addr/out_data stable through every stalled cycle; no word lost or duplicated.
- Pulse start again while busy (at word 7) -> dump unaffected, still exactly 32 words, single done pulse.
- Assert rst for one cycle during SEND1 of pair 4 -> next cycle out_valid=0, busy=0, rb_a1=rb_a2=0, no done; a fresh start dumps from addr 0.
- During a dump, write reg31=0x12345678 after pair 3 is read -> addr31 reports 0x12345678; a write to reg2 at the same time leaves the addr2 word at its prior value.
- Start with out_ready=0 held for 10 cycles after the first out_valid -> addr0 word held for all 10 cycles, transfers on the first cycle out_ready=1.
